parity_generator: RTL and testbench

Clocked even/odd parity generator with an integrated parity checker. It computes a parity bit for each valid input word and registers it alongside the word. A second input path checks received word+parity pairs and flags and counts mismatches. It sits at the edge of data links, generating parity on transmit and checking it on receive.

---
 rtl/parity_pkg.sv | 10 +
 rtl/parity_tree.sv | 12 +
 rtl/parity_generator.sv | 106 ++++++++++
 tb/tb_parity_generator.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared defaults and parity-mode encoding for the parity generator/checker.
package parity_pkg;

  localparam int unsigned DEF_DATA_W    = 4;
  localparam int unsigned DEF_ERR_CNT_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_tree.sv
// Combinational parity bit: XOR-reduction of the word, inverted in odd mode.
module parity_tree #(
  parameter int unsigned DATA_W = parity_pkg::DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              odd_sel,
  output logic              parity
);

  assign parity = (^data) ^ odd_sel;

endmodule

// File: rtl/parity_generator.sv
// Registered parity generator with an independent parity checker and error counter.
// Optional feature macro: PARITY_ERRCNT_EN enables the saturating err_count.
module parity_generator
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 odd_sel,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 parity,
  input  logic                 chk_valid,
  input  logic [DATA_W-1:0]    chk_data,
  input  logic                 chk_parity,
  output logic                 chk_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic gen_parity;
  logic exp_parity;
  logic mismatch;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              parity_q,    parity_d;
  logic              chk_err_q,   chk_err_d;

  parity_tree #(
    .DATA_W (DATA_W)
  ) u_gen_tree (
    .data    (in_data),
    .odd_sel (odd_sel),
    .parity  (gen_parity)
  );

  parity_tree #(
    .DATA_W (DATA_W)
  ) u_chk_tree (
    .data    (chk_data),
    .odd_sel (odd_sel),
    .parity  (exp_parity)
  );

  assign mismatch = chk_valid & (chk_parity != exp_parity);

  // Data and parity hold their last value while no word is presented.
  always_comb begin
    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    parity_d    = parity_q;
    if (in_valid) begin
      out_data_d = in_data;
      parity_d   = gen_parity;
    end
    chk_err_d = mismatch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      parity_q    <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      parity_q    <= parity_d;
      chk_err_q   <= chk_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign parity    = parity_q;
  assign chk_err   = chk_err_q;

`ifdef PARITY_ERRCNT_EN
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Saturate at all-ones rather than wrapping.
  always_comb begin
    err_count_d = err_count_q;
    if (mismatch && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_parity_generator.sv
// Directed self-checking bench for parity_generator (DATA_W=4, ERR_CNT_W=2).
module tb_parity_generator;
  import parity_pkg::*;

`ifdef PARITY_ERRCNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       odd_sel;
  logic       out_valid;
  logic [3:0] out_data;
  logic       parity;
  logic       chk_valid;
  logic [3:0] chk_data;
  logic       chk_parity;
  logic       chk_err;
  logic [1:0] err_count;

  int checks   = 0;
  int failures = 0;

  parity_generator #(
    .DATA_W    (4),
    .ERR_CNT_W (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .odd_sel    (odd_sel),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .parity     (parity),
    .chk_valid  (chk_valid),
    .chk_data   (chk_data),
    .chk_parity (chk_parity),
    .chk_err    (chk_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cnt(input int v);
    return CntEn ? 8'(v) : 8'd0;
  endfunction

  logic [3:0] gen_data [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b1011, 4'b0000, 4'b1101};
  logic       gen_par  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] sat_cnt  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    // Reset with both paths active and a would-be-bad check present
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 4'hF;
    odd_sel    = PAR_ODD;
    chk_valid  = 1'b1;
    chk_data   = 4'b1100;
    chk_parity = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_parity",    8'(parity),    8'd0);
    chk("rst_out_data",  8'(out_data),  8'd0);
    chk("rst_chk_err",   8'(chk_err),   8'd0);
    chk("rst_err_count", 8'(err_count), 8'd0);

    // Even generate, back-to-back
    rst       = 1'b0;
    chk_valid = 1'b0;
    odd_sel   = PAR_EVEN;
    for (int i = 0; i < 6; i++) begin
      in_data = gen_data[i];
      tick();
      chk("even_valid",  8'(out_valid), 8'd1);
      chk("even_data",   8'(out_data),  8'(gen_data[i]));
      chk("even_parity", 8'(parity),    8'(gen_par[i]));
    end

    // Odd generate
    odd_sel = PAR_ODD;
    in_data = 4'b0000;
    tick();
    chk("odd_0000_parity", 8'(parity), 8'd1);
    in_data = 4'b1011;
    tick();
    chk("odd_1011_parity", 8'(parity),   8'd0);
    chk("odd_1011_data",   8'(out_data), 8'b1011);

    // Drop in_valid: outputs hold even as inputs change
    in_valid = 1'b0;
    in_data  = 4'b0101;
    odd_sel  = PAR_EVEN;
    tick();
    chk("idle_valid",  8'(out_valid), 8'd0);
    chk("idle_data",   8'(out_data),  8'b1011);
    chk("idle_parity", 8'(parity),    8'd0);
    tick();
    chk("idle2_data",   8'(out_data), 8'b1011);
    chk("idle2_parity", 8'(parity),   8'd0);

    // Checker, even mode
    chk_valid  = 1'b1;
    chk_data   = 4'b1100;
    chk_parity = 1'b0;
    tick();
    chk("chk_good_err", 8'(chk_err),   8'd0);
    chk("chk_good_cnt", 8'(err_count), 8'd0);
    chk_parity = 1'b1;
    tick();
    chk("chk_bad_err", 8'(chk_err),   8'd1);
    chk("chk_bad_cnt", 8'(err_count), cnt(1));
    chk_valid = 1'b0;
    tick();
    chk("chk_pulse_end", 8'(chk_err),   8'd0);
    chk("chk_cnt_hold",  8'(err_count), cnt(1));

    // Saturation from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_cnt", 8'(err_count), 8'd0);
    chk_valid  = 1'b1;
    chk_data   = 4'b1100;
    chk_parity = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_err", 8'(chk_err),   8'd1);
      chk("sat_cnt", 8'(err_count), cnt(int'(sat_cnt[i])));
    end
    chk_valid = 1'b0;
    tick();
    chk("invalid_bad_err", 8'(chk_err),   8'd0);
    chk("invalid_bad_cnt", 8'(err_count), cnt(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_clr_cnt", 8'(err_count), 8'd0);
    chk("sat_clr_err", 8'(chk_err),   8'd0);

    // Checker, odd mode: 1011 has three ones, so expected parity is 0
    odd_sel    = PAR_ODD;
    chk_valid  = 1'b1;
    chk_data   = 4'b1011;
    chk_parity = 1'b0;
    tick();
    chk("odd_chk_good", 8'(chk_err), 8'd0);
    chk_parity = 1'b1;
    tick();
    chk("odd_chk_bad",     8'(chk_err),   8'd1);
    chk("odd_chk_bad_cnt", 8'(err_count), cnt(1));

    // Concurrency: generate 1101 odd -> parity 0; check 0111 odd expects 0, given 1
    in_valid   = 1'b1;
    in_data    = 4'b1101;
    chk_data   = 4'b0111;
    chk_parity = 1'b1;
    tick();
    chk("conc_valid",  8'(out_valid), 8'd1);
    chk("conc_data",   8'(out_data),  8'b1101);
    chk("conc_parity", 8'(parity),    8'd0);
    chk("conc_err",    8'(chk_err),   8'd1);
    chk("conc_cnt",    8'(err_count), cnt(2));

    // Mid-stream reset discards in-flight word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 8'(out_valid), 8'd0);
    chk("mid_rst_data",  8'(out_data),  8'd0);
    chk("mid_rst_err",   8'(chk_err),   8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
